// File: rtl/fp_exception_pipe.sv
// fp_exception_pipe: two-stage floating-point multiplier exception resolution with valid/ready flow control.
module fp_exception_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+1:0]       expt_pd,
  input  logic [MAN_W:0]         mantissa_pd,
  input  logic                   spd,
  input  logic [EXP_W-1:0]       expa,
  input  logic [EXP_W-1:0]       expb,
  input  logic [MAN_W-1:0]       manta,
  input  logic [MAN_W-1:0]       mantb,
  input  logic                   sa,
  input  logic                   sb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic [4:0]             flags,
  input  logic                   clr_flags,
  output logic [4:0]             sticky_flags
);
  logic v1, s1, sx, az, ai, an, bz, bi, bn;
  logic [EXP_W+1:0] e1;
  logic [MAN_W-1:0] m1;
  logic adv1, adv2, acc, xfer;
  logic inv, inf, zer, ovf, unf;
  logic [4:0] res_flags;
  logic [EXP_W+MAN_W:0] res;
  logic unused_hidden;
  assign unused_hidden = mantissa_pd[MAN_W];
  assign adv2 = !out_valid || out_ready;
  assign adv1 = v1 && adv2;
  assign in_ready = !v1 || adv1;
  assign acc = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      e1 <= '0;
      m1 <= '0;
      s1 <= 1'b0;
      sx <= 1'b0;
      {az, ai, an, bz, bi, bn} <= '0;
    end else begin
      v1 <= acc || (v1 && !adv1);
      if (acc) begin
        e1 <= expt_pd;
        m1 <= mantissa_pd[MAN_W-1:0];
        s1 <= spd;
        sx <= sa ^ sb;
        az <= expa == '0 && manta == '0;
        ai <= &expa && manta == '0;
        an <= &expa && |manta;
        bz <= expb == '0 && mantb == '0;
        bi <= &expb && mantb == '0;
        bn <= &expb && |mantb;
      end
    end
  end
  // priority chain: each class is masked by every earlier one, so at most one flag is set
  always_comb begin
    inv = an || bn || (ai && bz) || (bi && az);
    inf = !inv && (ai || bi);
    zer = !inv && !inf && (az || bz);
    ovf = !inv && !inf && !zer && !e1[EXP_W+1] && (e1[EXP_W] || &e1[EXP_W-1:0]);
    unf = !inv && !inf && !zer && !ovf && (e1[EXP_W+1] || e1 == '0);
    res_flags = {unf, ovf, zer, inf, inv};
    res = inv ? {1'b0, {EXP_W{1'b1}}, {{(MAN_W-1){1'b0}}, 1'b1}} :
          inf ? {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
          zer ? {sx, {(EXP_W+MAN_W){1'b0}}} :
          ovf ? {s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
          unf ? {s1, {(EXP_W+MAN_W){1'b0}}} :
                {s1, e1[EXP_W-1:0], m1};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product <= '0;
      flags <= '0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        product <= res;
        flags <= res_flags;
      end
    end
  end
  // a clear coinciding with a transfer keeps only that transfer's flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_flags <= '0;
    else if (clr_flags) sticky_flags <= xfer ? flags : '0;
    else if (xfer) sticky_flags <= sticky_flags | flags;
  end
endmodule
